// File: rtl/oipuf_crp_collector_if.sv
// PUF drive/capture lines plus the CRP valid/ready stream of oipuf_crp_collector.
// master = collector side, slave = PUF stub / CRP consumer side.
interface oipuf_crp_collector_if #(
  parameter int TW = 4,
  parameter int ST = 64
);
  logic          puf_trig;
  logic [ST-1:0] puf_chal;
  logic [TW-1:0] puf_resp;
  logic          puf_stable;
  logic          crp_valid;
  logic          crp_ready;
  logic [ST-1:0] crp_chal;
  logic [TW-1:0] crp_resp;
  logic          crp_xor;
  logic          crp_reliable;

  modport master (
    output puf_trig, puf_chal, crp_valid, crp_chal, crp_resp, crp_xor, crp_reliable,
    input  puf_resp, puf_stable, crp_ready
  );

  modport slave (
    input  puf_trig, puf_chal, crp_valid, crp_chal, crp_resp, crp_xor, crp_reliable,
    output puf_resp, puf_stable, crp_ready
  );
endinterface

// File: rtl/oipuf_crp_collector.sv
// Challenge generator / response collector for the OIPUF64x4 arbiter PUF.
// Define OIPUF_CRP_MAJORITY_EN for REPS-way majority voting; otherwise one sample per challenge.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | present next LFSR challenge, clear vote state
// ARM    | trigger low for one cycle
// FIRE   | trigger high SETTLE cycles, sample on the last one
// EMIT   | CRP valid, waiting for ready
// DONE   | one-cycle done pulse
module oipuf_crp_collector #(
  parameter int          TW     = 4,
  parameter int          ST     = 64,
  parameter int          SETTLE = 8,
  parameter int          REPS   = 5,
  parameter logic [63:0] SEED   = 64'h1444565890ABCDE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [15:0]          num_crp,
  output logic                 busy,
  output logic                 done,
  oipuf_crp_collector_if.master bus
);

`ifdef OIPUF_CRP_MAJORITY_EN
  localparam int REPS_EFF = REPS;
`else
  localparam int REPS_EFF = 1;
`endif
  localparam int          REP_W = $clog2(REPS + 1);
  localparam int          TMR_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [63:0] POLY  = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_FIRE, S_EMIT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  tmr;
  logic [REP_W-1:0]  rep_cnt;
  logic [15:0]       remaining;
  logic [63:0]       lfsr;
  logic [ST-1:0]     chal_q;
  logic [ST-1:0]     crp_chal_q;
  logic [TW-1:0]     crp_resp_q;
  logic              crp_xor_q;
  logic              crp_rel_q;
  logic              stable_acc;
  logic [TW-1:0]     vote;
  logic              agree;
  logic              fire_last;
  logic              rep_last;
  logic              trig;
  logic              valid;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  assign fire_last = (state == S_FIRE) && (tmr == '0);
  assign rep_last  = (rep_cnt == REP_W'(REPS_EFF - 1));

`ifdef OIPUF_CRP_MAJORITY_EN
  logic [TW-1:0][3:0] ones, ones_nxt;

  // vote and agreement are taken from the counts including the sample being captured
  always_comb begin
    ones_nxt = ones;
    vote     = '0;
    agree    = 1'b1;
    for (int i = 0; i < TW; i++) begin
      ones_nxt[i] = ones[i] + {3'b000, bus.puf_resp[i]};
      vote[i]     = ones_nxt[i] > 4'(REPS / 2);
      if (ones_nxt[i] != 4'd0 && ones_nxt[i] != 4'(REPS)) agree = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones <= '0;
    end else if (state == S_LOAD) begin
      ones <= '0;
    end else if (fire_last) begin
      ones <= ones_nxt;
    end
  end
`else
  assign vote  = bus.puf_resp;
  assign agree = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    trig      = 1'b0;
    valid     = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: if (start) state_nxt = (num_crp != 16'd0) ? S_LOAD : S_DONE;
      S_LOAD: state_nxt = S_ARM;
      S_ARM:  state_nxt = S_FIRE;
      S_FIRE: begin
        trig = 1'b1;
        if (tmr == '0) state_nxt = rep_last ? S_EMIT : S_ARM;
      end
      S_EMIT: begin
        valid = 1'b1;
        if (bus.crp_ready) state_nxt = (remaining <= 16'd1) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr        <= '0;
      rep_cnt    <= '0;
      remaining  <= '0;
      lfsr       <= SEED;
      chal_q     <= '0;
      stable_acc <= 1'b0;
      crp_chal_q <= '0;
      crp_resp_q <= '0;
      crp_xor_q  <= 1'b0;
      crp_rel_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start && num_crp != 16'd0) remaining <= num_crp;
        S_LOAD: begin
          chal_q     <= lfsr;
          lfsr       <= lfsr_step(lfsr);
          rep_cnt    <= '0;
          stable_acc <= 1'b1;
        end
        S_ARM: tmr <= TMR_W'(SETTLE - 1);
        S_FIRE: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else begin
            rep_cnt    <= rep_cnt + 1'b1;
            stable_acc <= stable_acc & bus.puf_stable;
            if (rep_last) begin
              crp_chal_q <= chal_q;
              crp_resp_q <= vote;
              crp_xor_q  <= ^vote;
              crp_rel_q  <= agree & stable_acc & bus.puf_stable;
            end
          end
        end
        S_EMIT: if (bus.crp_ready && remaining != 16'd0) remaining <= remaining - 16'd1;
        default: ;
      endcase
    end
  end

  assign bus.puf_trig     = trig;
  assign bus.puf_chal     = chal_q;
  assign bus.crp_valid    = valid;
  assign bus.crp_chal     = crp_chal_q;
  assign bus.crp_resp     = crp_resp_q;
  assign bus.crp_xor      = crp_xor_q;
  assign bus.crp_reliable = crp_rel_q;

endmodule

// File: tb/tb_oipuf_crp_collector.sv
// Self-checking bench for oipuf_crp_collector: constant-vector table, majority sequences,
// backpressure, zero count, ignored start, mid-run reset and randomized PUF responses.
module tb_oipuf_crp_collector;
  localparam int          TW     = 4;
  localparam int          ST     = 64;
  localparam int          SETTLE = 8;
  localparam int          REPS   = 5;
  localparam logic [63:0] SEED   = 64'h1444565890ABCDE1;
`ifdef OIPUF_CRP_MAJORITY_EN
  localparam int REPS_EFF = REPS;
`else
  localparam int REPS_EFF = 1;
`endif
  localparam int LAT = 1 + REPS_EFF * (SETTLE + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_crp = 16'd0;
  logic        busy, done;

  oipuf_crp_collector_if #(.TW(TW), .ST(ST)) bus ();

  oipuf_crp_collector #(
    .TW(TW), .ST(ST), .SETTLE(SETTLE), .REPS(REPS), .SEED(SEED)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .num_crp (num_crp),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // PUF stub: 0 = constant, 1 = five-entry sequence, 2 = random; every sample taken is queued
  int            stub_mode = 0;
  logic [TW-1:0] c_resp = '0;
  logic          c_stab = 1'b1;
  logic [TW-1:0] seq_resp [5];
  int            cfg_id = 0;
  int            cfg_seen = -1;
  int            sidx = 0;
  logic          trig_prev = 1'b0;
  bit            fresh = 1'b0;
  logic [TW:0]   samp_q [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      trig_prev = 1'b0;
    end else begin
      if (trig_prev && !bus.puf_trig) begin
        samp_q.push_back({bus.puf_resp, bus.puf_stable});
        sidx++;
        fresh = 1'b1;
      end
      trig_prev = bus.puf_trig;
    end
    if (cfg_id != cfg_seen) begin
      cfg_seen = cfg_id;
      sidx     = 0;
      fresh    = 1'b1;
    end
    if (fresh) begin
      case (stub_mode)
        1: begin
          bus.puf_resp   = seq_resp[sidx % 5];
          bus.puf_stable = 1'b1;
        end
        2: begin
          bus.puf_resp   = TW'($urandom);
          bus.puf_stable = ($urandom_range(0, 3) != 0);
        end
        default: begin
          bus.puf_resp   = c_resp;
          bus.puf_stable = c_stab;
        end
      endcase
      fresh = 1'b0;
    end
  end

  logic [63:0] m_lfsr = SEED;

  // x^64+x^63+x^61+x^60+1, Galois (right-shifting) form
  function automatic logic [63:0] ref_next(input logic [63:0] s);
    logic [63:0] taps;
    taps = (64'd1 << 63) | (64'd1 << 62) | (64'd1 << 60) | (64'd1 << 59);
    return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string name);
    check(name, {busy, done, bus.puf_trig, bus.crp_valid, bus.crp_xor, bus.crp_reliable,
                 bus.puf_chal, bus.crp_chal, bus.crp_resp}, '0);
  endtask

  task automatic idle_window(input int len);
    int nv, nd;
    nv = 0;
    nd = 0;
    for (int k = 0; k < len; k++) begin
      tick;
      if (bus.crp_valid) nv++;
      if (done) nd++;
    end
    check("idle_no_valid", nv, 0);
    check("idle_no_done", nd, 0);
  endtask

  task automatic run(input int n, input int stall, input bit rnd_stall, input bit poke,
                     input bit seed_chk, input bit tbl_en, input logic [TW-1:0] t_resp,
                     input logic t_xor, input logic t_rel);
    int            cnt, st;
    int            ones [TW];
    logic [63:0]   e_chal;
    logic [TW-1:0] e_resp;
    logic          e_xor, e_rel;
    logic [TW:0]   s;
    num_crp = 16'(n);
    start   = 1'b1;
    tick;
    start = 1'b0;
    if (n == 0) begin
      check("zero_done", {done, bus.crp_valid}, 2'b10);
      tick;
      check("zero_done_end", {done, busy}, 2'b00);
      idle_window(LAT + 10);
      return;
    end
    for (int j = 0; j < n; j++) begin
      cnt = 0;
      while (!bus.crp_valid && cnt < LAT + 50) begin
        if (poke && j == 0 && cnt == 10) begin
          num_crp = 16'd7;
          start   = 1'b1;
        end else begin
          start = 1'b0;
        end
        tick;
        cnt++;
      end
      start = 1'b0;
      if (!bus.crp_valid) begin
        n_vec++;
        n_bad++;
        $display("FAIL valid_timeout: crp_valid low after %0d cycles, required by %0d", cnt, LAT);
        return;
      end
      check("latency", cnt, LAT);
      e_chal = m_lfsr;
      m_lfsr = ref_next(m_lfsr);
      for (int b = 0; b < TW; b++) ones[b] = 0;
      e_rel = 1'b1;
      for (int k = 0; k < REPS_EFF; k++) begin
        if (samp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL sample_count: %0d samples seen, required %0d", k, REPS_EFF);
          s = '0;
        end else begin
          s = samp_q.pop_front();
        end
        e_rel &= s[0];
        for (int b = 0; b < TW; b++) ones[b] += int'(s[b+1]);
      end
      for (int b = 0; b < TW; b++) begin
        e_resp[b] = (2 * ones[b] > REPS_EFF);
        if (ones[b] != 0 && ones[b] != REPS_EFF) e_rel = 1'b0;
      end
      e_xor = ^e_resp;
      check("crp_chal", bus.crp_chal, e_chal);
      check("puf_chal_hold", bus.puf_chal, e_chal);
      check("crp_resp", bus.crp_resp, e_resp);
      check("crp_xor", bus.crp_xor, e_xor);
      check("crp_reliable", bus.crp_reliable, e_rel);
      if (seed_chk && j == 0) check("first_chal_seed", bus.crp_chal, SEED);
      if (tbl_en) check("tbl_expect", {bus.crp_resp, bus.crp_xor, bus.crp_reliable},
                        {t_resp, t_xor, t_rel});
      st = rnd_stall ? int'($urandom_range(0, 3)) : stall;
      for (int k = 0; k < st; k++) begin
        tick;
        check("stall_hold", {bus.crp_valid, bus.puf_trig, bus.crp_chal, bus.crp_resp,
                             bus.crp_xor, bus.crp_reliable},
              {1'b1, 1'b0, e_chal, e_resp, e_xor, e_rel});
      end
      bus.crp_ready = 1'b1;
      tick;
      bus.crp_ready = 1'b0;
    end
    check("done_after_hs", {done, bus.crp_valid}, 2'b10);
    tick;
    check("done_single", {done, busy}, 2'b00);
    idle_window(poke ? LAT + 10 : 12);
  endtask

  typedef struct {
    int            n;
    int            stall;
    logic [TW-1:0] resp;
    logic          stab;
    logic [TW-1:0] e_resp;
    logic          e_xor;
    logic          e_rel;
  } vec_t;

  vec_t tbl [5];
  int   rst_at;

  initial begin
    tbl[0] = '{1, 0,  4'b1010, 1'b1, 4'b1010, 1'b0, 1'b1};
    tbl[1] = '{1, 0,  4'b0111, 1'b1, 4'b0111, 1'b1, 1'b1};
    tbl[2] = '{2, 0,  4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[3] = '{1, 2,  4'b1111, 1'b1, 4'b1111, 1'b0, 1'b1};
    tbl[4] = '{3, 20, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1};

    bus.crp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick;
    check_reset_vals("reset_state");
    rst_n = 1'b1;
    tick;
    check_reset_vals("idle_after_release");

    for (int i = 0; i < 5; i++) begin
      stub_mode = 0;
      c_resp    = tbl[i].resp;
      c_stab    = tbl[i].stab;
      cfg_id++;
      tick;
      run(tbl[i].n, tbl[i].stall, 1'b0, 1'b0, (i == 0), 1'b1,
          tbl[i].e_resp, tbl[i].e_xor, tbl[i].e_rel);
    end

    // bit0 is 1 on three of five samples
    stub_mode   = 1;
    seq_resp[0] = 4'b1011; seq_resp[1] = 4'b1010; seq_resp[2] = 4'b1011;
    seq_resp[3] = 4'b1010; seq_resp[4] = 4'b1011;
    cfg_id++;
    tick;
`ifdef OIPUF_CRP_MAJORITY_EN
    run(1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b0);
`else
    run(1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1);
`endif

    // bit0 is 0 on three of five samples
    seq_resp[0] = 4'b1010; seq_resp[1] = 4'b1011; seq_resp[2] = 4'b1010;
    seq_resp[3] = 4'b1011; seq_resp[4] = 4'b1010;
    cfg_id++;
    tick;
`ifdef OIPUF_CRP_MAJORITY_EN
    run(1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, 1'b0);
`else
    run(1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, 1'b1);
`endif

    stub_mode = 0;
    c_resp    = 4'b0110;
    c_stab    = 1'b1;
    cfg_id++;
    tick;
    run(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    run(2, 0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b1);

    stub_mode = 2;
    cfg_id++;
    tick;
    run(4, 0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    run(3, 0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // reset while the trigger is high (second rep when voting, first otherwise)
    stub_mode = 0;
    c_resp    = 4'b1100;
    c_stab    = 1'b1;
    cfg_id++;
    tick;
    rst_at  = (REPS_EFF > 1) ? (1 + (SETTLE + 1) + 1 + 3) : 5;
    num_crp = 16'd2;
    start   = 1'b1;
    tick;
    start = 1'b0;
    repeat (rst_at) tick;
    check("fire_before_reset", {bus.puf_trig, busy}, 2'b11);
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid_run");
    repeat (3) tick;
    check_reset_vals("reset_held");
    samp_q.delete();
    m_lfsr = SEED;
    rst_n  = 1'b1;
    tick;
    run(1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1100, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/oipuf_crp_collector.md
# oipuf_crp_collector

- Sequential driver and reader for the OIPUF64x4 arbiter-PUF core; it is the challenge-issuing, response-capturing end of the `tigReg`/`iC`/`resp` interface.
- On `start` it generates `num_crp` pseudo-random 64-bit challenges with an internal LFSR.
- For each challenge it fires the PUF `REPS` times, majority-votes each response bit and grades reliability.
- It streams every challenge-response pair (CRP) out over a valid/ready port to the CRP logger/UART.

## Interface
- `TW`, default 4: PUF arbiter chains per challenge; width of the response.
- `ST`, default 64: challenge width; the LFSR is fixed at 64 bits, so `ST` must be 64.
- `SETTLE`, default 8: cycles `puf_trig` is held high before sampling; must be ≥1.
- `REPS`, default 5: evaluations per challenge; must be odd, range 1..15.
- `SEED`, default 64'h1444565890ABCDE1: LFSR reset value; must be non-zero.
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `num_crp`  in  16  number of CRPs to produce; captured when `start` is accepted.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `puf_trig`  out  1  drives PUF `tigReg`.
- `puf_chal`  out  ST  drives PUF `iC`.
- `puf_resp`  in  TW  PUF per-chain responses.
- `puf_stable`  in  1  PUF overall stability flag.
- `crp_valid`  out  1  CRP available.
- `crp_ready`  in  1  consumer accepts the CRP.
- `crp_chal`  out  ST  challenge of the CRP.
- `crp_resp`  out  TW  majority-voted response.
- `crp_xor`  out  1  XOR of the `crp_resp` bits.
- `crp_reliable`  out  1  1 = every sample agreed and `puf_stable` was high at every sample.

## Operation
- **States:** IDLE, LOAD, ARM, FIRE, EMIT, DONE.
- **IDLE:**
  - `start`=1 with `num_crp`≠0: capture the count, go to LOAD.
  - `start`=1 with `num_crp`=0: go to DONE.
  - `start` outside IDLE is ignored.
- **LOAD:**
  - `puf_chal` ← current LFSR state; the LFSR then advances one step.
  - Polynomial: Galois form of x^64+x^63+x^61+x^60+1.
  - Clear per-bit ones counters, the rep counter and the stable-AND accumulator; go to ARM.
  - The first challenge after reset equals `SEED`.
  - The LFSR is not reseeded by `start`; consecutive runs continue the sequence.
- **ARM:** `puf_trig`=0 for 1 cycle; go to FIRE.
- **FIRE:**
  - `puf_trig`=1 for `SETTLE` cycles.
  - On the last FIRE cycle: for each bit i, `ones[i]` += `puf_resp[i]`; the stable-AND accumulator &= `puf_stable`; the rep counter is incremented.
  - If the rep counter < `REPS`, go to ARM; otherwise go to EMIT.
- **EMIT:**
  - `crp_valid`=1.
  - `crp_resp[i]` = (`ones[i]` > `REPS`/2).
  - `crp_reliable` = (every `ones[i]` equals 0 or `REPS`) AND the stable-AND accumulator.
  - All `crp_*` outputs are registered and held stable while valid is high and ready is low.
  - On valid&&ready: decrement the remaining count; if it is non-zero go to LOAD, else go to DONE.
- **DONE:** `done`=1 for one cycle; go to IDLE.
- `puf_chal` holds its value between LOADs.
- `puf_trig` is 0 in every state except FIRE.

## Timing
- **Reset values:** state IDLE; `busy`, `done`, `puf_trig`, `crp_valid`, `crp_xor`, `crp_reliable` = 0; `puf_chal`, `crp_chal`, `crp_resp` = 0; LFSR = `SEED`; all counters 0.
- **Start to first valid:** `crp_valid` rises 1+`REPS`×(`SETTLE`+1) cycles after the edge that samples `start` (46 with default parameters).
- **Back-to-back CRPs:** the next `crp_valid` rises 1+`REPS`×(`SETTLE`+1) cycles after the accepting handshake edge.
- **Backpressure:** while EMIT waits for `crp_ready`, the PUF is idle (`puf_trig`=0) and no evaluation proceeds.
- **Done timing:**
  - The `done` pulse follows the final handshake by one cycle.
  - With `num_crp`=0, `done` is high in the cycle after `start` was sampled.
- **Reset mid-run:** all outputs return to their reset values immediately (asynchronous); no partial CRP is emitted; the LFSR is reseeded.
- **Counter wrap:** `num_crp`=16'hFFFF produces 65535 CRPs; the remaining-count decrement never wraps below 0.

## Configuration
- **`OIPUF_CRP_MAJORITY_EN` defined:** behaviour is as above.
- **`OIPUF_CRP_MAJORITY_EN` undefined:**
  - `REPS` is ignored and treated as 1; the ones counters are removed.
  - `crp_resp` = `puf_resp` sampled on the last FIRE cycle.
  - `crp_reliable` = `puf_stable` at that sample.
  - Start-to-valid latency becomes 1+(`SETTLE`+1), i.e. 10 with defaults.

## Test plan
- **Single run:** defaults, PUF stub returns constant 4'b1010 with `puf_stable`=1, `num_crp`=1, `crp_ready`=1.
  - `crp_valid` rises 46 cycles after `start`.
  - `crp_chal`=64'h1444565890ABCDE1, `crp_resp`=4'b1010, `crp_xor`=0, `crp_reliable`=1.
  - `done` is high one cycle after the handshake.
- **Majority vote:** stub flips bit0 on 2 of 5 samples (sequence 1,0,1,0,1).
  - `crp_resp[0]`=1 and `crp_reliable`=0.
  - With 3 of 5 zeros, `crp_resp[0]`=0.
- **Backpressure:** `num_crp`=3, `crp_ready` held low for 20 cycles on each CRP.
  - `crp_*` stay stable and `puf_trig` stays 0 during the stall.
  - Exactly 3 handshakes occur, with successive LFSR challenges.
  - `done` pulses once.
- **Zero count and ignored start:**
  - `num_crp`=0: `done` is high the cycle after `start`; `crp_valid` never rises.
  - A second `start` pulsed mid-run (while `busy`) is ignored.
- **Reset mid-run:** assert `rst_n`=0 in FIRE of the second rep.
  - All outputs return to reset values.
  - After release, the next run's first `crp_chal`=`SEED`.
- **Macro off:** build without `OIPUF_CRP_MAJORITY_EN`, stub with `puf_stable`=0.
  - Latency is 10 cycles and `crp_reliable`=0.
